// File: rtl/bka_pkg.sv
// Shared types and elaboration helpers for the Brent-Kung adder slice.
// No logic; imported by the prefix tree and the pipelined top.
// No handshake of its own.
package bka_pkg;

    localparam int BKA_MAX_WIDTH = 64;

    typedef struct packed {
        logic p;
        logic g;
    } bka_pg_t;

    typedef enum logic {
        BKA_ADD = 1'b0,
        BKA_SUB = 1'b1
    } bka_op_e;

    function automatic int bka_levels(input int width);
        int lvl;
        lvl = 0;
        for (int i = 0; i < 7; i++) begin
            if ((1 << i) < width) lvl = i + 1;
        end
        return lvl;
    endfunction

endpackage

// File: rtl/bka_prefix_tree.sv
// Brent-Kung prefix network, split at the up-sweep/down-sweep boundary.
// Latency: purely combinational.
// Backpressure: none; the caller registers (or not) between the two halves.
module bka_prefix_tree
    import bka_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] up_p,
    input  logic [WIDTH-1:0] up_g,
    output logic [WIDTH-1:0] mid_p,
    output logic [WIDTH-1:0] mid_g,
    input  logic [WIDTH-1:0] dn_p,
    input  logic [WIDTH-1:0] dn_g,
    input  logic             dn_cin,
    output logic [WIDTH-1:0] carry
);

    localparam int LVL = bka_levels(WIDTH);

    function automatic bka_pg_t black(input bka_pg_t hi, input bka_pg_t lo);
        bka_pg_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

    // After the up-sweep, node i spans bits [i : i+1-lowbit(i+1)].
    always_comb begin : up_sweep
        bka_pg_t [WIDTH-1:0] t;
        for (int i = 0; i < WIDTH; i++) begin
            t[i] = '{p: up_p[i], g: up_g[i]};
        end
        for (int k = 0; k < LVL; k++) begin
            for (int i = (2 << k) - 1; i < WIDTH; i += (2 << k)) begin
                t[i] = black(t[i], t[i - (1 << k)]);
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            mid_p[i] = t[i].p;
            mid_g[i] = t[i].g;
        end
    end

    // Each gray cell closes its span against the carry just below it; c[0] is c_in.
    always_comb begin : down_sweep
        logic [WIDTH:0] c;
        int             span;
        c    = '0;
        c[0] = dn_cin;
        for (int i = 0; i < WIDTH; i++) begin
            span     = (i + 1) & -(i + 1);
            c[i + 1] = dn_g[i] | (dn_p[i] & c[i + 1 - span]);
        end
        carry = c[WIDTH:1];
    end

endmodule

// File: rtl/bka_pipe_adder.sv
// Pipelined Brent-Kung add/sub with carry-out and signed overflow; BKA_PIPE_SAT_EN saturates q.
// Latency: STAGES cycles (1..3) per accepted beat, plus one cycle per stall cycle.
// Backpressure: all ranks advance together on out_ready | ~out_valid; in_ready is that term.
module bka_pipe_adder
    import bka_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             ovf
);

    logic adv;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    bka_op_e          op;
    logic [WIDTH-1:0] b_x;
    logic             c_x;
    assign op  = sub ? BKA_SUB : BKA_ADD;
    assign b_x = (op == BKA_SUB) ? ~b : b;
    assign c_x = cin ^ sub;

    logic [WIDTH-1:0] s1_a, s1_b;
    logic             s1_c, s1_vld;
    generate
        if (STAGES >= 2) begin : g_in_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_vld <= 1'b0;
                    s1_a   <= '0;
                    s1_b   <= '0;
                    s1_c   <= 1'b0;
                end else if (adv) begin
                    s1_vld <= in_valid;
                    s1_a   <= a;
                    s1_b   <= b_x;
                    s1_c   <= c_x;
                end
            end
        end else begin : g_in_pass
            assign s1_vld = in_valid;
            assign s1_a   = a;
            assign s1_b   = b_x;
            assign s1_c   = c_x;
        end
    endgenerate

    logic [WIDTH-1:0] s1_p, s1_g, up_p, up_g;
    assign s1_p = s1_a ^ s1_b;
    assign s1_g = s1_a & s1_b;

    logic [WIDTH-1:0] s2_p, s2_gp, s2_gg, carry;
    logic             s2_c, s2_vld;
    generate
        if (STAGES >= 3) begin : g_mid_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_vld <= 1'b0;
                    s2_p   <= '0;
                    s2_gp  <= '0;
                    s2_gg  <= '0;
                    s2_c   <= 1'b0;
                end else if (adv) begin
                    s2_vld <= s1_vld;
                    s2_p   <= s1_p;
                    s2_gp  <= up_p;
                    s2_gg  <= up_g;
                    s2_c   <= s1_c;
                end
            end
        end else begin : g_mid_pass
            assign s2_vld = s1_vld;
            assign s2_p   = s1_p;
            assign s2_gp  = up_p;
            assign s2_gg  = up_g;
            assign s2_c   = s1_c;
        end
    endgenerate

    bka_prefix_tree #(.WIDTH(WIDTH)) u_tree (
        .up_p   (s1_p),
        .up_g   (s1_g),
        .mid_p  (up_p),
        .mid_g  (up_g),
        .dn_p   (s2_gp),
        .dn_g   (s2_gg),
        .dn_cin (s2_c),
        .carry  (carry)
    );

    logic [WIDTH-1:0] sum, q_nxt;
    logic             ovf_nxt;
    assign sum     = s2_p ^ {carry[WIDTH-2:0], s2_c};
    assign ovf_nxt = carry[WIDTH-1] ^ carry[WIDTH-2];

`ifdef BKA_PIPE_SAT_EN
    // A positive overflow always wraps to a negative sum, so the wrapped sign selects the limit.
    assign q_nxt = ovf_nxt ? {~sum[WIDTH-1], {(WIDTH-1){sum[WIDTH-1]}}} : sum;
`else
    assign q_nxt = sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            q         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_vld;
            q         <= q_nxt;
            cout      <= carry[WIDTH-1];
            ovf       <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_bka_pipe_adder.sv
// Bench for bka_pipe_adder: directed corner beats plus random streams under backpressure,
// scored against an integer a +/- b model with handshake-aware latency tracking.
module tb_bka_pipe_adder;

    localparam int W = 32;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] q;
    logic         cout;
    logic         ovf;

    bka_pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [W-1:0] q;
        logic         cout;
        logic         ovf;
        int           n;
    } exp_t;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sb);
        exp_t             e;
        logic signed [W+1:0] sx, sy, r;
        logic [W+1:0]     ux, uy, u, uc;
        sx = {{2{x[W-1]}}, x};
        sy = {{2{y[W-1]}}, y};
        ux = {2'b00, x};
        uy = {2'b00, y};
        uc = {{(W+1){1'b0}}, ci};
        if (sb) begin
            r      = sx - sy - $signed(uc);
            u      = ux - uy - uc;
            e.cout = ~u[W+1];
        end else begin
            r      = sx + sy + $signed(uc);
            u      = ux + uy + uc;
            e.cout = u[W];
        end
        e.ovf = (r > $signed({3'b000, {(W-1){1'b1}}})) || (r < $signed({3'b111, {(W-1){1'b0}}}));
        e.q   = r[W-1:0];
`ifdef BKA_PIPE_SAT_EN
        if (e.ovf) e.q = (r < 0) ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        e.n = 0;
        return e;
    endfunction

    // Scoreboard: accepted beats queue up; each must surface after exactly S advancing edges.
    exp_t          sb_q[$];
    int            adv_cnt = 0;
    bit            acc = 0;
    bit            stall = 0;
    logic [W+1:0]  held;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
            stall = 0;
            acc   = 0;
        end else begin
            chk("in_ready", {63'd0, in_ready}, {63'd0, out_ready | ~out_valid});
            if (stall) begin
                chk("hold_vld", {63'd0, out_valid}, 64'd1);
                chk("hold_dat", {30'd0, q, cout, ovf}, {30'd0, held});
            end
            stall = out_valid && !out_ready;
            held  = {q, cout, ovf};
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_beat", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("q", {32'd0, q}, {32'd0, e.q});
                    chk("cout_ovf", {62'd0, cout, ovf}, {62'd0, e.cout, e.ovf});
                    chk("latency", 64'(adv_cnt - e.n), 64'(S));
                end
            end
            acc = in_valid && in_ready;
            if (acc) begin
                e   = model(a, b, cin, sub);
                e.n = adv_cnt;
                sb_q.push_back(e);
            end
            if (in_ready) adv_cnt++;
        end
    end

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One beat into an empty pipe with out_ready high; result checked against constants.
    task automatic send_one(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic ci, input logic sb,
                            input logic [W-1:0] eq, input logic ec, input logic eo);
        idle(S + 2);
        in_valid = 1'b1; a = x; b = y; cin = ci; sub = sb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (S > 1) repeat (S - 1) @(posedge clk);
        #1;
        chk({tag, "_vld"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_q"}, {32'd0, q}, {32'd0, eq});
        chk({tag, "_cout"}, {63'd0, cout}, {63'd0, ec});
        chk({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    // mode 0: random out_ready, 1: repeating 1,0,0 pattern, 2: always ready.
    task automatic run_random(input int ncyc, input int mode);
        for (int c = 0; c < ncyc; c++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a        = rnd_op();
                b        = rnd_op();
                cin      = 1'($urandom_range(0, 1));
                sub      = 1'($urandom_range(0, 1));
            end
            case (mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = (c % 3 == 0);
                default: out_ready = 1'b1;
            endcase
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", {63'd0, out_valid}, 64'd0);
        chk("rst_q", {32'd0, q}, 64'd0);
        chk("rst_flags", {62'd0, cout, ovf}, 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_rdy", {63'd0, in_ready}, 64'd1);

        send_one("carry_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
`ifdef BKA_PIPE_SAT_EN
        send_one("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        send_one("neg_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
`else
        send_one("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        send_one("neg_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif
        send_one("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send_one("sub_equal", 32'h0000_0009, 32'h0000_0009, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        send_one("ones_cin", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        send_one("sub_bin", 32'h0000_0009, 32'h0000_0009, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);

        run_random(3000, 0);
        run_random(600, 1);
        run_random(1000, 2);

        // Reset with two beats in flight: nothing of them may surface afterwards.
        idle(S + 2);
        in_valid = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        a = 32'h0BAD_F00D;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_vld", {63'd0, out_valid}, 64'd0);
        chk("midrst_q", {32'd0, q}, 64'd0);
        chk("midrst_flags", {62'd0, cout, ovf}, 64'd0);
        for (int i = 0; i < S + 1; i++) begin
            @(posedge clk); #1;
            chk("midrst_flush", {63'd0, out_valid}, 64'd0);
        end
        send_one("post_rst", 32'h0000_0003, 32'h0000_0004, 1'b1, 1'b0, 32'h0000_0008, 1'b0, 1'b0);

        idle(1);
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
